sp_ram_initiator: RTL and testbench
===================================

// Module: sp_ram_initiator
// PURPOSE
//  Initiator side of the single-port SRAM macro wrapper interface (en/we/be/addr/wdata -> rdata).
//  Converts a core-style req/gnt/rvalid data bus into per-cycle macro accesses.
//  Owns the 1-cycle read latency, read-data hold, and a memory-clear engine run after reset or on demand.
//  Sits between the interconnect slave port and one sp wrapper instance.
// PARAMETERS
//  DW             32     data width, multiple of 8
//  AW             10     word address width (2**AW words)
//  CTRL_W         5      ram_ctrl width (5 = EMA/EMAW macro, 4 = RTSEL/WTSEL macro)
//  RAM_CTRL_VAL   5'b00010  constant driven on ram_ctrl_o
//  INIT_ON_RESET  1      1: clear memory after reset; 0: READY directly after reset
//  INIT_VALUE     '0     DW-bit word written by the clear engine
// PORTS
//  clk           in   1         clock, all state on rising edge
//  rst           in   1         synchronous reset, active-high
//  req_i         in   1         bus request
//  gnt_o         out  1         bus grant (combinational)
//  addr_i        in   32        byte address
//  we_i          in   1         1 = write, 0 = read
//  be_i          in   DW/8      byte enables (writes only)
//  wdata_i       in   DW        write data
//  rvalid_o      out  1         response valid, 1 cycle after grant
//  rdata_o       out  DW        read data
//  init_req_i    in   1         start clear engine (pulse)
//  init_done_o   out  1         high when READY, low while clearing
//  ram_en_o      out  1         macro enable
//  ram_we_o      out  1         macro write enable
//  ram_be_o      out  DW/8      macro byte enables
//  ram_addr_o    out  AW        macro word address
//  ram_wdata_o   out  DW        macro write data
//  ram_rdata_i   in   DW        macro read data, valid the cycle after a read
//  ram_ctrl_o    out  CTRL_W    timing-margin control = RAM_CTRL_VAL
// BEHAVIOUR
//  Reset: state = INIT if INIT_ON_RESET, else READY.
//    Reset values: init_cnt=0, rvalid_o=0, rdata_o=0, init_done_o=0 (1 if INIT_ON_RESET=0).
//    Reset mid-clear restarts the clear from address 0. Reset mid-read drops that rvalid.
//  INIT state: gnt_o=0; ram_en_o=1, ram_we_o=1, ram_be_o=all-ones, ram_wdata_o=INIT_VALUE, ram_addr_o=init_cnt.
//    init_cnt increments each cycle. On init_cnt==2**AW-1, next state READY, init_done_o=1 next cycle.
//    Clear takes exactly 2**AW cycles. init_req_i is ignored while in INIT.
//  READY state: gnt_o=req_i & ~init_req_i; ram_en_o=gnt_o; ram_we_o=we_i; ram_be_o=be_i.
//    ram_wdata_o=wdata_i.
//    ram_addr_o=addr_i[AW+log2(DW/8)-1:log2(DW/8)]; upper bits are ignored, so addresses wrap modulo 2**AW words.
//    Low byte-offset bits are ignored.
//  init_req_i in READY: next state INIT, init_cnt=0, init_done_o drops next cycle.
//    A same-cycle req_i is not granted.
//  Response: rvalid_o=1 exactly one cycle after every grant, for reads and writes. Back-to-back grants give back-to-back rvalid.
//    Read response: rdata_o = ram_rdata_i in the rvalid cycle. Data is captured into hold_q and held until the next read response.
//    Write response: rdata_o keeps the last read data.
//  A read granted in the last READY cycle before INIT still gets its rvalid and data in the first INIT cycle.
//  Read after write, same address, back-to-back: the read returns the new data (macro is write-first per access, no bypass needed).
//  ram_ctrl_o is constant, including during reset.
// STRUCTURE
//  Package sp_ram_pkg: typedef enum logic {INIT, READY} sp_ram_state_e; CTRL_W defaults per technology (5/4).
//  Single module, no sub-modules. Registers: state, init_cnt[AW-1:0], rvalid_q, rd_pending_q, hold_q[DW-1:0].
//  All RAM-side outputs are combinational from state/bus inputs, with no added latency.
// TESTING
//  1 Reset with INIT_ON_RESET=1, AW=4 -> 16 writes of INIT_VALUE to addr 0..15, gnt_o=0 throughout.
//    init_done_o rises at cycle 17.
//  2 Write 0xDEADBEEF to 0x8 (be=4'hF), read 0x8 -> rvalid 1 cycle after each grant, rdata_o=0xDEADBEEF.
//  3 Write be=4'b0010 data 0x0000AB00 to a cleared word, read back -> 0x0000AB00; rdata_o then holds across an idle cycle and a write.
//  4 Back-to-back reads at 0x0, 0x4, 0x40 with AW=4 -> three consecutive rvalid.
//    0x40 wraps to word 0, so its data equals word 0.
//  5 init_req_i together with req_i in READY -> no grant, re-clear of all words; a previously written word reads INIT_VALUE afterwards.
//  6 rst asserted at init_cnt=7 -> clear restarts at addr 0; in-flight read rvalid is suppressed after reset.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// rtl/sp_ram_pkg.sv - shared types and constants for the single-port SRAM initiator
package sp_ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sp_ram_state_e;

    // ram_ctrl width per macro family: EMA/EMAW macros vs RTSEL/WTSEL macros
    localparam int CTRL_W_EMA   = 5;
    localparam int CTRL_W_RTSEL = 4;

endpackage

// File: rtl/sp_ram_initiator.sv
// rtl/sp_ram_initiator.sv - req/gnt/rvalid bus to single-port SRAM macro access converter with clear engine
module sp_ram_initiator
    import sp_ram_pkg::*;
#(
    parameter int                 DW            = 32,
    parameter int                 AW            = 10,
    parameter int                 CTRL_W        = CTRL_W_EMA,
    parameter logic [CTRL_W-1:0]  RAM_CTRL_VAL  = CTRL_W'(5'b00010),
    parameter bit                 INIT_ON_RESET = 1'b1,
    parameter logic [DW-1:0]      INIT_VALUE    = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic [31:0]         addr_i,
    input  logic                we_i,
    input  logic [DW/8-1:0]     be_i,
    input  logic [DW-1:0]       wdata_i,
    output logic                rvalid_o,
    output logic [DW-1:0]       rdata_o,
    input  logic                init_req_i,
    output logic                init_done_o,
    output logic                ram_en_o,
    output logic                ram_we_o,
    output logic [DW/8-1:0]     ram_be_o,
    output logic [AW-1:0]       ram_addr_o,
    output logic [DW-1:0]       ram_wdata_o,
    input  logic [DW-1:0]       ram_rdata_i,
    output logic [CTRL_W-1:0]   ram_ctrl_o
);

    localparam int OFF = $clog2(DW/8);

    sp_ram_state_e   state_q, state_d;
    logic [AW-1:0]   init_cnt_q, init_cnt_d;
    logic            rvalid_q;
    logic            rd_pending_q;
    logic [DW-1:0]   hold_q;

    logic [31:0]     addr_word;
    logic            unused_addr;

    // Byte address to word address; bits above AW are dropped so accesses wrap
    assign addr_word   = addr_i >> OFF;
    assign unused_addr = ^addr_word[31:AW];

    always_comb begin
        gnt_o       = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        if (state_q == INIT) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_be_o    = '1;
            ram_addr_o  = init_cnt_q;
            ram_wdata_o = INIT_VALUE;
            init_cnt_d  = init_cnt_q + AW'(1);
            if (&init_cnt_q) begin
                state_d = READY;
            end
        end else begin
            gnt_o       = req_i & ~init_req_i;
            ram_en_o    = gnt_o;
            ram_we_o    = we_i;
            ram_be_o    = be_i;
            ram_addr_o  = addr_word[AW-1:0];
            ram_wdata_o = wdata_i;
            if (init_req_i) begin
                state_d    = INIT;
                init_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT_ON_RESET ? INIT : READY;
            init_cnt_q   <= '0;
            rvalid_q     <= 1'b0;
            rd_pending_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            rvalid_q     <= gnt_o;
            rd_pending_q <= gnt_o & ~we_i;
            if (rd_pending_q) begin
                hold_q <= ram_rdata_i;
            end
        end
    end

    // Macro data is live only in the response cycle; afterwards the held copy is shown
    assign rdata_o     = rd_pending_q ? ram_rdata_i : hold_q;
    assign rvalid_o    = rvalid_q;
    assign init_done_o = (state_q == READY);
    assign ram_ctrl_o  = RAM_CTRL_VAL;

endmodule

// File: tb/tb_sp_ram_initiator.sv
// tb/tb_sp_ram_initiator.sv - self-checking bench for sp_ram_initiator with a request-level reference model
module tb_sp_ram_initiator;

    localparam int             DW     = 32;
    localparam int             AW     = 4;
    localparam int             NW     = 16;
    localparam logic [DW-1:0]  INIT_V = '0;
    localparam logic [4:0]     CTRL_V = 5'b00010;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_i = 1'b0;
    logic           gnt_o;
    logic [31:0]    addr_i = '0;
    logic           we_i = 1'b0;
    logic [3:0]     be_i = '0;
    logic [31:0]    wdata_i = '0;
    logic           rvalid_o;
    logic [31:0]    rdata_o;
    logic           init_req_i = 1'b0;
    logic           init_done_o;
    logic           ram_en_o;
    logic           ram_we_o;
    logic [3:0]     ram_be_o;
    logic [AW-1:0]  ram_addr_o;
    logic [31:0]    ram_wdata_o;
    logic [31:0]    ram_rdata_i;
    logic [4:0]     ram_ctrl_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sp_ram_initiator #(
        .DW            (DW),
        .AW            (AW),
        .CTRL_W        (5),
        .RAM_CTRL_VAL  (CTRL_V),
        .INIT_ON_RESET (1'b1),
        .INIT_VALUE    (INIT_V)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .init_req_i  (init_req_i),
        .init_done_o (init_done_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .ram_ctrl_o  (ram_ctrl_o)
    );

    // SRAM macro stand-in, pre-filled with junk so the clear is observable
    logic [31:0] sram [NW];
    logic [31:0] sram_q = '0;
    bit          filled = 1'b0;
    assign ram_rdata_i = sram_q;

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < NW; i++) sram[i] <= 32'h1111_1111 * (i + 1);
            filled <= 1'b1;
        end else if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) sram[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            end else begin
                sram_q <= sram[ram_addr_o];
            end
        end
    end

    // Reference model state: words still to clear, memory image, pending response
    int          m_left = NW;
    logic [31:0] m_mem [NW];
    bit          m_resp_valid = 1'b0;
    bit          m_resp_read  = 1'b0;
    logic [31:0] m_resp_data  = '0;
    logic [31:0] m_last       = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          rdy;
        bit          g;
        int          widx;
        logic [31:0] exp_rdata;
        rdy  = (m_left == 0);
        g    = rdy && req_i && !init_req_i;
        widx = int'(addr_i[5:2]);
        chk("ram_ctrl", 32'(ram_ctrl_o), 32'(CTRL_V));
        if (!rst) begin
            chk("init_done", 32'(init_done_o), 32'(rdy));
            chk("gnt", 32'(gnt_o), 32'(g));
            chk("ram_en", 32'(ram_en_o), rdy ? 32'(g) : 32'd1);
            if (!rdy) begin
                chk("clr_we", 32'(ram_we_o), 32'd1);
                chk("clr_be", 32'(ram_be_o), 32'hF);
                chk("clr_addr", 32'(ram_addr_o), 32'(NW - m_left));
                chk("clr_wdata", ram_wdata_o, INIT_V);
            end else begin
                chk("ram_we", 32'(ram_we_o), 32'(we_i));
                chk("ram_be", 32'(ram_be_o), 32'(be_i));
                chk("ram_addr", 32'(ram_addr_o), 32'(widx));
                chk("ram_wdata", ram_wdata_o, wdata_i);
            end
            exp_rdata = (m_resp_valid && m_resp_read) ? m_resp_data : m_last;
            chk("rvalid", 32'(rvalid_o), 32'(m_resp_valid));
            chk("rdata", rdata_o, exp_rdata);
        end
        if (m_resp_valid && m_resp_read) m_last = m_resp_data;
        m_resp_valid = g;
        m_resp_read  = !we_i;
        m_resp_data  = m_mem[widx];
        if (!rdy) begin
            m_mem[NW - m_left] = INIT_V;
            m_left--;
        end else if (g && we_i) begin
            for (int b = 0; b < 4; b++)
                if (be_i[b]) m_mem[widx][b*8 +: 8] = wdata_i[b*8 +: 8];
        end else if (init_req_i) begin
            m_left = NW;
        end
        if (rst) begin
            m_left       = NW;
            m_resp_valid = 1'b0;
            m_last       = '0;
        end
    endtask

    task automatic drive(input bit r, input bit rq, input bit we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] d, input bit ir);
        rst = r; req_i = rq; we_i = we; addr_i = a; be_i = be; wdata_i = d; init_req_i = ir;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        drive(1'b0, 1'b1, 1'b1, a, be, d, 1'b0);
        chk("wr_rvalid", 32'(rvalid_o), 32'd1);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, 1'b1, 1'b0, a, 4'h0, 32'h0, 1'b0);
        chk({name, "_rvalid"}, 32'(rvalid_o), 32'd1);
        chk(name, rdata_o, exp);
    endtask

    task automatic wait_ready(input string name, input int exp_edges);
        int k;
        k = 0;
        while (!init_done_o && k < 40) begin
            idle();
            k++;
        end
        chk(name, 32'(k), 32'(exp_edges));
    endtask

    initial begin
        // 1: reset then full clear of 16 words
        repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("reset_rvalid", 32'(rvalid_o), 32'd0);
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_done", 32'(init_done_o), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        wait_ready("clear_len", 15);

        // 2: full-word write and read back
        wr(32'h8, 4'hF, 32'hDEAD_BEEF);
        rd("rd_deadbeef", 32'h8, 32'hDEAD_BEEF);

        // 3: partial byte write to a cleared word, then hold across idle and write
        wr(32'hC, 4'b0010, 32'h0000_AB00);
        rd("rd_partial", 32'hC, 32'h0000_AB00);
        idle();
        chk("hold_idle", rdata_o, 32'h0000_AB00);
        wr(32'h10, 4'hF, 32'h5555_AAAA);
        chk("hold_write", rdata_o, 32'h0000_AB00);

        // 4: back-to-back reads with address wrap
        wr(32'h0, 4'hF, 32'hCAFE_0001);
        wr(32'h4, 4'hF, 32'h0BAD_0002);
        rd("b2b_0", 32'h0, 32'hCAFE_0001);
        rd("b2b_1", 32'h4, 32'h0BAD_0002);
        rd("b2b_wrap", 32'h40, 32'hCAFE_0001);
        rd("rd_after_wr", 32'h10, 32'h5555_AAAA);
        wr(32'h3F7, 4'hF, 32'h7777_0003);
        rd("wrap_hi", 32'h34, 32'h7777_0003);

        // 5: init request with a same-cycle request
        wr(32'h14, 4'hF, 32'h1234_5678);
        rd("pre_clear", 32'h14, 32'h1234_5678);
        drive(1'b0, 1'b1, 1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF, 1'b1);
        chk("init_no_rvalid", 32'(rvalid_o), 32'd0);
        chk("init_done_drop", 32'(init_done_o), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        wait_ready("reclear_len", 15);
        rd("post_clear", 32'h14, INIT_V);
        rd("post_clear_b", 32'h8, INIT_V);

        // 6: reset with a read in flight, then reset again mid-clear
        drive(1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("rst_drop_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'h0);
        repeat (7) idle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("rst_mid_done", 32'(init_done_o), 32'd0);
        wait_ready("restart_len", 16);
        rd("after_restart", 32'h4, INIT_V);
        repeat (2) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
